// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD engine and its step datapath.
package gcd_pkg;

    typedef enum logic [1:0] {StIdle, StCalc, StFin, StDone} state_e;

    localparam int unsigned MODE_EUCLID = 0;
    localparam int unsigned MODE_STEIN  = 1;

    // Wide enough to count every common factor of two that a WIDTH-bit operand can hold.
    function automatic int unsigned k_width(int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: termination detect plus a single Euclid or Stein reduction.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned MODE  = MODE_EUCLID
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic             k_inc_o,
    output logic             term_o,
    output logic [WIDTH-1:0] r_o
);

    always_comb begin
        x_o     = x_i;
        y_o     = y_i;
        k_inc_o = 1'b0;
        term_o  = 1'b0;
        r_o     = '0;
        if (x_i == '0) begin
            term_o = 1'b1;
            r_o    = y_i;
        end else if (y_i == '0) begin
            term_o = 1'b1;
            r_o    = x_i;
        end else if (x_i == y_i) begin
            term_o = 1'b1;
            r_o    = x_i;
        end else if (MODE == MODE_STEIN) begin
            // Shared factors of two are stripped first and restored later via k.
            if (!x_i[0] && !y_i[0]) begin
                x_o     = x_i >> 1;
                y_o     = y_i >> 1;
                k_inc_o = 1'b1;
            end else if (!x_i[0]) begin
                x_o = x_i >> 1;
            end else if (!y_i[0]) begin
                y_o = y_i >> 1;
            end else if (x_i > y_i) begin
                x_o = x_i - y_i;
            end else begin
                y_o = y_i - x_i;
            end
        end else begin
            if (x_i > y_i) begin
                x_o = x_i - y_i;
            end else begin
                y_o = y_i - x_i;
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// Handshaked GCD engine: accepts an operand pair, iterates gcd_step once per cycle, and holds
// the result and saturating step count until the consumer takes them.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned MODE  = MODE_EUCLID,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [CNT_W-1:0] out_steps,
    output logic             busy
);

    localparam int unsigned KW = k_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, r_q, r_d, gcd_q, gcd_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CNT_W-1:0] count_q, count_d, steps_q, steps_d;

    logic [WIDTH-1:0] step_x, step_y, step_r;
    logic             step_k_inc, step_term;

    gcd_step #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_step (
        .x_i     (x_q),
        .y_i     (y_q),
        .x_o     (step_x),
        .y_o     (step_y),
        .k_inc_o (step_k_inc),
        .term_o  (step_term),
        .r_o     (step_r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            count_q <= '0;
            gcd_q   <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            k_q     <= k_d;
            count_q <= count_d;
            gcd_q   <= gcd_d;
            steps_q <= steps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        k_d     = k_q;
        count_d = count_q;
        gcd_d   = gcd_q;
        steps_d = steps_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    k_d     = '0;
                    count_d = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (step_term) begin
                    r_d     = step_r;
                    state_d = StFin;
                end else begin
                    x_d = step_x;
                    y_d = step_y;
                    if (step_k_inc) begin
                        k_d = k_q + 1'b1;
                    end
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StFin: begin
                // Cannot overflow: the restored value is the true gcd, never above an operand.
                gcd_d   = r_q << k_q;
                steps_d = count_q;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StCalc) || (state_q == StFin);
        out_gcd   = gcd_q;
        out_steps = steps_q;
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench: a Euclid engine with an 8-bit step counter and a Stein engine with a
// 16-bit counter, driven with directed vectors and checked by per-engine monitors.
module tb_gcd_engine;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned CNT_E   = 8;
    localparam int unsigned CNT_S   = 16;
    localparam int          TIMEOUT = 70000;

    typedef struct {
        logic [WIDTH-1:0] gcd;
        int               steps;
        int               lat;
        int               acc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_x, in_y;

    logic             in_valid_e, in_ready_e, out_valid_e, out_ready_e, busy_e;
    logic [WIDTH-1:0] out_gcd_e;
    logic [CNT_E-1:0] out_steps_e;

    logic             in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s;
    logic [WIDTH-1:0] out_gcd_s;
    logic [CNT_S-1:0] out_steps_s;

    exp_t q_e[$];
    exp_t q_s[$];
    int   cyc;
    int   n_vec;
    int   n_bad;

    gcd_engine #(
        .WIDTH (WIDTH),
        .MODE  (0),
        .CNT_W (CNT_E)
    ) u_euclid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_e),
        .in_ready  (in_ready_e),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid_e),
        .out_ready (out_ready_e),
        .out_gcd   (out_gcd_e),
        .out_steps (out_steps_e),
        .busy      (busy_e)
    );

    gcd_engine #(
        .WIDTH (WIDTH),
        .MODE  (1),
        .CNT_W (CNT_S)
    ) u_stein (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .out_gcd   (out_gcd_s),
        .out_steps (out_steps_s),
        .busy      (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic summary_and_finish();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL timeout waiting for %s (cycle %0d)", name, cyc);
        summary_and_finish();
    endtask

    // Monitors sample on the falling edge; a handshake seen here completes on the next rise.
    initial begin : mon_e
        int   rise;
        bit   seen;
        exp_t e;
        seen = 1'b0;
        rise = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                seen = 1'b0;
            end else if (out_valid_e) begin
                if (!seen) begin
                    seen = 1'b1;
                    rise = cyc;
                end
                if (out_ready_e) begin
                    seen = 1'b0;
                    if (q_e.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL euclid unexpected output: got gcd %0d, expected none",
                                 out_gcd_e);
                    end else begin
                        e = q_e.pop_front();
                        check("euclid gcd", out_gcd_e, e.gcd);
                        check("euclid steps", out_steps_e, e.steps);
                        check("euclid latency", rise - e.acc, e.lat);
                    end
                end
            end
        end
    end

    initial begin : mon_s
        int   rise;
        bit   seen;
        exp_t e;
        seen = 1'b0;
        rise = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                seen = 1'b0;
            end else if (out_valid_s) begin
                if (!seen) begin
                    seen = 1'b1;
                    rise = cyc;
                end
                if (out_ready_s) begin
                    seen = 1'b0;
                    if (q_s.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL stein unexpected output: got gcd %0d, expected none",
                                 out_gcd_s);
                    end else begin
                        e = q_s.pop_front();
                        check("stein gcd", out_gcd_s, e.gcd);
                        check("stein steps", out_steps_s, e.steps);
                        check("stein latency", rise - e.acc, e.lat);
                    end
                end
            end
        end
    end

    task automatic issue_e(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic [WIDTH-1:0] g, input int st, input int lat,
                           input bit push);
        int n;
        n = 0;
        while (!in_ready_e) begin
            @(posedge clk);
            #1;
            n++;
            if (n > TIMEOUT) timeout("euclid in_ready");
        end
        in_x       = x;
        in_y       = y;
        in_valid_e = 1'b1;
        @(posedge clk);
        #1;
        in_valid_e = 1'b0;
        if (push) q_e.push_back('{gcd: g, steps: st, lat: lat, acc: cyc});
    endtask

    task automatic issue_s(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic [WIDTH-1:0] g, input int st, input int lat);
        int n;
        n = 0;
        while (!in_ready_s) begin
            @(posedge clk);
            #1;
            n++;
            if (n > TIMEOUT) timeout("stein in_ready");
        end
        in_x       = x;
        in_y       = y;
        in_valid_s = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s = 1'b0;
        q_s.push_back('{gcd: g, steps: st, lat: lat, acc: cyc});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_e.size() != 0 || q_s.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > TIMEOUT) timeout("result");
        end
    endtask

    task automatic run_e(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [WIDTH-1:0] g, input int st, input int lat);
        issue_e(x, y, g, st, lat, 1'b1);
        drain();
    endtask

    task automatic run_s(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [WIDTH-1:0] g, input int st, input int lat);
        issue_s(x, y, g, st, lat);
        drain();
    endtask

    task automatic check_reset_values();
        check("reset euclid in_ready", in_ready_e, 1);
        check("reset euclid out_valid", out_valid_e, 0);
        check("reset euclid busy", busy_e, 0);
        check("reset euclid out_gcd", out_gcd_e, 0);
        check("reset euclid out_steps", out_steps_e, 0);
        check("reset stein in_ready", in_ready_s, 1);
        check("reset stein out_valid", out_valid_s, 0);
        check("reset stein out_gcd", out_gcd_s, 0);
        check("reset stein out_steps", out_steps_s, 0);
    endtask

    initial begin : stim
        int n;
        n_vec       = 0;
        n_bad       = 0;
        rst         = 1'b0;
        in_x        = '0;
        in_y        = '0;
        in_valid_e  = 1'b0;
        in_valid_s  = 1'b0;
        out_ready_e = 1'b1;
        out_ready_s = 1'b1;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // (48,18): Euclid 4 steps, Stein 6 steps with one shared factor of two
        run_e(16'd48, 16'd18, 16'd6, 4, 6);
        run_s(16'd48, 16'd18, 16'd6, 6, 8);

        // Zero operands finish without stepping
        run_e(16'd0, 16'd35, 16'd35, 0, 2);
        run_e(16'd35, 16'd0, 16'd35, 0, 2);
        run_e(16'd0, 16'd0, 16'd0, 0, 2);
        run_s(16'd0, 16'd35, 16'd35, 0, 2);
        run_s(16'd35, 16'd0, 16'd35, 0, 2);
        run_s(16'd0, 16'd0, 16'd0, 0, 2);

        // Backpressure: result held, input closed, stray in_valid dropped
        out_ready_e = 1'b0;
        issue_e(16'd12, 16'd8, 16'd4, 2, 4, 1'b1);
        n = 0;
        while (!out_valid_e) begin
            @(posedge clk);
            #1;
            n++;
            if (n > TIMEOUT) timeout("euclid out_valid");
        end
        for (int i = 0; i < 5; i++) begin
            check("bp gcd held", out_gcd_e, 4);
            check("bp steps held", out_steps_e, 2);
            check("bp out_valid held", out_valid_e, 1);
            check("bp in_ready low", in_ready_e, 0);
            in_x       = 16'd99;
            in_y       = 16'd33;
            in_valid_e = (i == 2);
            @(posedge clk);
            #1;
        end
        in_valid_e  = 1'b0;
        out_ready_e = 1'b1;
        @(posedge clk);
        #1;
        check("bp idle after handshake", in_ready_e, 1);
        check("bp out_valid dropped", out_valid_e, 0);
        @(posedge clk);
        #1;
        check("bp stray in_valid ignored", busy_e, 0);
        check("bp scoreboard empty", q_e.size(), 0);

        // Extreme operands: Euclid counter saturates at 255 of 65534 real steps
        run_s(16'hFFFF, 16'd1, 16'd1, 30, 32);
        run_e(16'hFFFF, 16'd1, 16'd1, 255, 65536);

        // Asynchronous reset in the middle of a long calculation
        issue_e(16'd1000, 16'd3, 16'd0, 0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        check("midop busy before reset", busy_e, 1);
        rst = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_e(16'd21, 16'd14, 16'd7, 2, 4);
        run_s(16'd21, 16'd14, 16'd7, 3, 5);

        repeat (3) @(posedge clk);
        summary_and_finish();
    end

endmodule
